// File: rtl/nexys_starship_pkg.sv
// Shared lane indices, one-hot state codes and LFSR taps
// for the starship monster spawner.
package nexys_starship_pkg;

  localparam int LANE_TOP    = 0;
  localparam int LANE_BOTTOM = 1;
  localparam int LANE_LEFT   = 2;
  localparam int LANE_RIGHT  = 3;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_GAP  = 5'b00010;
  localparam logic [4:0] S_PICK = 5'b00100;
  localparam logic [4:0] S_REQ  = 5'b01000;
  localparam logic [4:0] S_HALT = 5'b10000;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [3:0] lane_mask_t;

  function automatic lane_mask_t lane_onehot(input logic [1:0] lane);
    return lane_mask_t'(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// 16-bit right-shifting Galois LFSR, free-running outside reset.
// A zero seed would lock up, so it is replaced by 1.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr <= seed_eff;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

endmodule

// File: rtl/nexys_starship_spawner.sv
// Monster spawner: waits a random tick gap, picks a random empty
// lane and holds a one-hot request until that lane acknowledges.
module nexys_starship_spawner
  import nexys_starship_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned GAP_BASE  = 2,
  parameter int unsigned GAP_BITS  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] lane_empty,
  input  logic [3:0] spawn_ack,
  output logic [3:0] spawn_req,
  output logic [7:0] spawn_count,
  output logic       q_Idle,
  output logic       q_Gap,
  output logic       q_Pick,
  output logic       q_Req,
  output logic       q_Halt
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_BASE + (1 << GAP_BITS)) + 1;

  logic [4:0]    state;
  logic [PW-1:0] prescaler;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_load;
  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic          tick;
  logic [1:0]    cand;
  logic [1:0]    scan_idx;
  logic [1:0]    pick_lane;
  logic          pick_found;

  nexys_starship_lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr;
  assign tick     = (prescaler == PW'(TICK_DIV - 1));
  assign gap_load = GW'(GAP_BASE) + GW'(lfsr[GAP_BITS-1:0]);
  assign cand     = lfsr[1:0];

  // Scan from highest offset down so offset 0 (cand) wins.
  always_comb begin
    pick_found = 1'b0;
    pick_lane  = cand;
    scan_idx   = cand;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = cand + 2'(k);
      if (lane_empty[scan_idx]) begin
        pick_found = 1'b1;
        pick_lane  = scan_idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      spawn_req   <= 4'b0000;
      spawn_count <= 8'd0;
      prescaler   <= '0;
      gap_cnt     <= '0;
    end else if (state == S_IDLE) begin
      if (play_flag && !game_over) begin
        state       <= S_GAP;
        spawn_count <= 8'd0;
        prescaler   <= '0;
        gap_cnt     <= gap_load;
      end
    end else if (game_over && state != S_HALT) begin
      state     <= S_HALT;
      spawn_req <= 4'b0000;
    end else if (!play_flag) begin
      state     <= S_IDLE;
      spawn_req <= 4'b0000;
    end else begin
      case (state)
        S_GAP: begin
          if (tick) begin
            prescaler <= '0;
            gap_cnt   <= gap_cnt - GW'(1);
            if (gap_cnt == GW'(1)) begin
              state <= S_PICK;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        S_PICK: begin
          if (pick_found) begin
            spawn_req <= lane_onehot(pick_lane);
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if ((spawn_ack & spawn_req) != 4'b0000) begin
            spawn_req <= 4'b0000;
            if (spawn_count != 8'hFF) begin
              spawn_count <= spawn_count + 8'd1;
            end
            prescaler <= '0;
            gap_cnt   <= gap_load;
            state     <= S_GAP;
          end
        end
        default: begin
          spawn_req <= 4'b0000;
        end
      endcase
    end
  end

  assign q_Idle = state[0];
  assign q_Gap  = state[1];
  assign q_Pick = state[2];
  assign q_Req  = state[3];
  assign q_Halt = state[4];

endmodule
